// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types, plus the state encoding used by the request arbiter.
package axi_lite_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  // NOTE: every output gets a default before the search loop, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_grant && req[(int'(ptr) + i) % NUM_REQ]) begin
        any_grant                                   = 1'b1;
        grant_idx                                   = IDX_W'((int'(ptr) + i) % NUM_REQ);
        grant_onehot[(int'(ptr) + i) % NUM_REQ]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_req_arbiter.sv
// Shares one AXI-Lite master control port between NUM_REQ requesters, one
// outstanding transaction at a time, granted round-robin.
module axi_lite_req_arbiter
  import axi_lite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [31:0]           mst_waddr,
  output logic [31:0]           mst_wdata,
  output logic                  mst_start_write,
  input  logic                  mst_w_done,
  input  logic                  mst_w_error,
  output logic [31:0]           mst_raddr,
  output logic                  mst_start_read,
  input  logic [31:0]           mst_rdata,
  input  logic                  mst_r_done,
  input  logic                  mst_r_error
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic               write_q, write_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  data_t              rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic               busy_q, busy_d;
  addr_t              mst_waddr_q, mst_waddr_d;
  data_t              mst_wdata_q, mst_wdata_d;
  addr_t              mst_raddr_q, mst_raddr_d;
  logic               start_w_q, start_w_d;
  logic               start_r_q, start_r_d;

  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req          (req_valid),
    .ptr          (rr_ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any_grant    (any_grant)
  );

  // Outputs are computed from the next state, so each registered output lines
  // up with the state it belongs to (start in ISSUE, rsp_valid in RESP).
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    write_d     = write_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    mst_waddr_d = mst_waddr_q;
    mst_wdata_d = mst_wdata_q;
    mst_raddr_d = mst_raddr_q;
    start_w_d   = 1'b0;
    start_r_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_grant) begin
          state_d     = ISSUE;
          req_ready_d = grant_onehot;
          gnt_d       = grant_idx;
          write_d     = req_write[grant_idx];
          rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          if (req_write[grant_idx]) begin
            mst_waddr_d = req_addr[int'(grant_idx)*32 +: 32];
            mst_wdata_d = req_wdata[int'(grant_idx)*32 +: 32];
            start_w_d   = 1'b1;
          end else begin
            mst_raddr_d = req_addr[int'(grant_idx)*32 +: 32];
            start_r_d   = 1'b1;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Only the done of the issued direction counts; the other may be stale.
        if (write_q ? mst_w_done : mst_r_done) begin
          state_d            = RESP;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_error_d        = write_q ? mst_w_error : mst_r_error;
          rsp_rdata_d        = write_q ? '0 : mst_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too, because every output must
    // read 0 while reset is applied.
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      write_q     <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      busy_q      <= 1'b0;
      mst_waddr_q <= '0;
      mst_wdata_q <= '0;
      mst_raddr_q <= '0;
      start_w_q   <= 1'b0;
      start_r_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      write_q     <= write_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      busy_q      <= busy_d;
      mst_waddr_q <= mst_waddr_d;
      mst_wdata_q <= mst_wdata_d;
      mst_raddr_q <= mst_raddr_d;
      start_w_q   <= start_w_d;
      start_r_q   <= start_r_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_error       = rsp_error_q;
  assign busy            = busy_q;
  assign mst_waddr       = mst_waddr_q;
  assign mst_wdata       = mst_wdata_q;
  assign mst_raddr       = mst_raddr_q;
  assign mst_start_write = start_w_q;
  assign mst_start_read  = start_r_q;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Bench for axi_lite_req_arbiter: behavioural master with sticky done flags,
// scoreboard of expected responses, directed stimulus.
module tb_axi_lite_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_write = '0;
  logic [NUM_REQ*32-1:0] req_addr  = '0;
  logic [NUM_REQ*32-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    req_ready, rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_error, busy;
  logic [31:0]           mst_waddr, mst_wdata, mst_raddr, mst_rdata;
  logic                  mst_start_write, mst_start_read;
  logic                  mst_w_done, mst_w_error, mst_r_done, mst_r_error;

  axi_lite_req_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_error       (rsp_error),
    .busy            (busy),
    .mst_waddr       (mst_waddr),
    .mst_wdata       (mst_wdata),
    .mst_start_write (mst_start_write),
    .mst_w_done      (mst_w_done),
    .mst_w_error     (mst_w_error),
    .mst_raddr       (mst_raddr),
    .mst_start_read  (mst_start_read),
    .mst_rdata       (mst_rdata),
    .mst_r_done      (mst_r_done),
    .mst_r_error     (mst_r_error)
  );

  always #5 clk = ~clk;

  // Master model: rising start clears sticky done, done rises mst_lat+1 cycles later.
  int          mst_lat  = 2;
  logic        slv_werr = 1'b0;
  logic        slv_rerr = 1'b0;
  logic        pre_en   = 1'b0;
  logic [31:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [16];
  logic        sw_p, sr_p, w_pend, r_pend;
  int          w_cnt, r_cnt;
  logic [31:0] wa, wd, ra;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr[5:2]] <= pre_data;
    if (!rst) begin
      mst_w_done <= 1'b0; mst_w_error <= 1'b0; mst_r_done <= 1'b0; mst_r_error <= 1'b0;
      w_pend <= 1'b0; r_pend <= 1'b0; sw_p <= 1'b0; sr_p <= 1'b0;
      w_cnt <= 0; r_cnt <= 0; mst_rdata <= '0;
    end else begin
      sw_p <= mst_start_write;
      sr_p <= mst_start_read;
      if (mst_start_write && !sw_p) begin
        mst_w_done <= 1'b0; w_pend <= 1'b1; w_cnt <= mst_lat; wa <= mst_waddr; wd <= mst_wdata;
      end else if (w_pend) begin
        if (w_cnt == 0) begin
          w_pend <= 1'b0; mst_w_done <= 1'b1; mst_w_error <= slv_werr;
          if (!slv_werr) mem[wa[5:2]] <= wd;
        end else w_cnt <= w_cnt - 1;
      end
      if (mst_start_read && !sr_p) begin
        mst_r_done <= 1'b0; r_pend <= 1'b1; r_cnt <= mst_lat; ra <= mst_raddr;
      end else if (r_pend) begin
        if (r_cnt == 0) begin
          r_pend <= 1'b0; mst_r_done <= 1'b1; mst_r_error <= slv_rerr; mst_rdata <= mem[ra[5:2]];
        end else r_cnt <= r_cnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          ready_cnt[NUM_REQ];
  int          rsp_cnt = 0;
  int          sw_hi = 0, sw_edges = 0, sr_edges = 0;
  logic        mon_sw_p = 1'b0, mon_sr_p = 1'b0;
  logic [31:0] last_waddr = '0, last_wdata = '0;

  initial for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;

  // Monitor samples 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (mst_start_write) begin
      sw_hi++;
      if (!mon_sw_p) sw_edges++;
      last_waddr = mst_waddr;
      last_wdata = mst_wdata;
    end
    if (mst_start_read && !mon_sr_p) sr_edges++;
    mon_sw_p = mst_start_write;
    mon_sr_p = mst_start_read;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) begin
        ready_cnt[i]++;
        grant_log.push_back(i);
      end
    if (rsp_valid != '0) begin
      rsp_cnt++;
      if (sb.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_onehot", 32'(rsp_valid), 32'(1 << e.idx));
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_error", 32'(rsp_error), 32'(e.err));
      end
    end
  end

  task automatic wait_ready(input int idx);
    bit got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = req_ready[idx];
    end
    check($sformatf("ready%0d", idx), 32'(got), 32'd1);
  endtask

  task automatic issue(input int idx, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] exp_rd, input bit exp_err);
    sb.push_back('{idx, exp_rd, exp_err});
    req_write[idx]         = wr;
    req_addr[idx*32 +: 32]  = addr;
    req_wdata[idx*32 +: 32] = data;
    req_valid[idx]         = 1'b1;
    wait_ready(idx);
    req_valid[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_start_w"}, 32'(mst_start_write), 32'd0);
    check({tag, "_start_r"}, 32'(mst_start_read), 32'd0);
    check({tag, "_waddr"}, mst_waddr, 32'd0);
    check({tag, "_raddr"}, mst_raddr, 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_error"}, 32'(rsp_error), 32'd0);
  endtask

  initial begin
    int c0, c1, c2, g0;

    // Reset state, with the read location preloaded in the master model.
    pre_en = 1'b1; pre_addr = 32'h20; pre_data = 32'h1234_5678;
    repeat (3) @(negedge clk);
    pre_en = 1'b0;
    check_outputs_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single write from requester 0.
    c0 = sw_hi; c1 = ready_cnt[0];
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    drain();
    check("wr_ready_once", 32'(ready_cnt[0] - c1), 32'd1);
    check("wr_start_1cyc", 32'(sw_hi - c0), 32'd1);
    check("wr_waddr", last_waddr, 32'h10);
    check("wr_wdata", last_wdata, 32'hDEAD_BEEF);

    // Single read from requester 2.
    issue(2, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);
    drain();

    // Error path: SLVERR write, then a clean read must report no error.
    slv_werr = 1'b1;
    issue(3, 1'b1, 32'h30, 32'hA5A5_A5A5, 32'h0, 1'b1);
    drain();
    slv_werr = 1'b0;
    issue(0, 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0);
    drain();

    // Back-to-back write then read of the same address by requester 1.
    mst_lat = 0;
    c0 = sw_edges; c1 = sr_edges;
    sb.push_back('{1, 32'h0, 1'b0});
    sb.push_back('{1, 32'hCAFE_F00D, 1'b0});
    req_write[1] = 1'b1; req_addr[32 +: 32] = 32'h40; req_wdata[32 +: 32] = 32'hCAFE_F00D;
    req_valid[1] = 1'b1;
    wait_ready(1);
    req_write[1] = 1'b0;
    wait_ready(1);
    req_valid[1] = 1'b0;
    drain();
    check("b2b_w_edges", 32'(sw_edges - c0), 32'd1);
    check("b2b_r_edges", 32'(sr_edges - c1), 32'd1);
    mst_lat = 2;

    // Reset in IDLE brings rr_ptr to 0, then fairness with all four requesting.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    g0 = grant_log.size();
    for (int i = 0; i < 8; i++) sb.push_back('{i % NUM_REQ, 32'h0, 1'b0});
    for (int i = 0; i < NUM_REQ; i++) begin
      req_write[i] = 1'b1;
      req_addr[i*32 +: 32]  = 32'h100 + 32'(i * 4);
      req_wdata[i*32 +: 32] = 32'(i);
    end
    req_valid = '1;
    for (int k = 0; k < 200 && grant_log.size() < g0 + 8; k++) @(negedge clk);
    req_valid = '0;
    check("fair_grants", 32'(grant_log.size() - g0), 32'd8);
    drain();
    for (int i = 0; i < 8 && g0 + i < grant_log.size(); i++)
      check($sformatf("fair_order%0d", i), 32'(grant_log[g0 + i]), 32'(i % NUM_REQ));

    // Reset while a read from requester 2 waits on a slow master.
    mst_lat = 10;
    req_write[2] = 1'b0; req_addr[64 +: 32] = 32'h20; req_valid[2] = 1'b1;
    wait_ready(2);
    req_valid[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_wait");
    rst = 1'b1;
    mst_lat = 1;
    c2 = rsp_cnt;
    repeat (15) @(negedge clk);
    check("no_rsp_after_rst", 32'(rsp_cnt - c2), 32'd0);

    // With rr_ptr back at 0, requester 1 must win over requester 3.
    g0 = grant_log.size();
    sb.push_back('{1, 32'h0, 1'b0});
    sb.push_back('{3, 32'h0, 1'b0});
    req_write[1] = 1'b1; req_write[3] = 1'b1;
    req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    for (int k = 0; k < 100 && req_valid != '0; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) req_valid[i] = 1'b0;
    end
    drain();
    check("post_rst_grants", 32'(grant_log.size() - g0), 32'd2);
    if (grant_log.size() >= g0 + 2) begin
      check("post_rst_first", 32'(grant_log[g0]), 32'd1);
      check("post_rst_second", 32'(grant_log[g0 + 1]), 32'd3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_req_arbiter.md
Name: axi_lite_req_arbiter

Overview:
Shares one axi_lite_master control port between NUM_REQ independent requesters. Each requester issues single read or write commands. Grants are round-robin. Exactly one transaction is outstanding at any time. The block sequences the master's edge-triggered start / sticky done handshake and returns the response (read data and error flag) to the granted requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, $clog2(NUM_REQ), width of the grant index

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester command pending; held until req_ready
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*32  packed addr_t per requester
req_wdata  in  NUM_REQ*32  packed data_t per requester (ignored for reads)
req_ready  out  NUM_REQ  one-hot 1-cycle accept pulse
rsp_valid  out  NUM_REQ  one-hot 1-cycle response pulse
rsp_rdata  out  32  read data; valid with rsp_valid, 0 after writes
rsp_error  out  1  response error; valid with rsp_valid
busy  out  1  high in every state except IDLE
mst_waddr / mst_wdata  out  32 each  to master waddr / wdata
mst_start_write  out  1  to master start_write
mst_w_done / mst_w_error  in  1 each  from master
mst_raddr  out  32  to master raddr
mst_start_read  out  1  to master start_read
mst_rdata  in  32  from master rdata
mst_r_done / mst_r_error  in  1 each  from master

Behaviour:
- All state and outputs are registered.
- Reset (rst low at a clk edge): state = IDLE, rr_ptr = 0, all outputs 0.
- Reset mid-transaction drops the transaction silently; no rsp_valid is issued. The master must share the same rst.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - If any req_valid is set, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Pulse req_ready[g] for that cycle only.
  - Latch g, req_write[g], req_addr[g] and req_wdata[g].
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Go to ISSUE.
  - No request: stay in IDLE; rr_ptr is unchanged.
- ISSUE (exactly 1 cycle):
  - Drive mst_waddr/mst_wdata or mst_raddr from the latched values.
  - Assert mst_start_write (write) or mst_start_read (read) for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - Start is low; the address/data outputs hold.
  - Exit on the selected done (mst_w_done or mst_r_done) == 1.
  - On exit, capture mst_r_error/mst_w_error and, for reads, mst_rdata.
  - Go to RESP.
  - Ignore the non-selected done.
  - No timeout; the arbiter waits indefinitely.
- RESP (1 cycle): rsp_valid[g] = 1 with rsp_rdata and rsp_error, then go to IDLE.
- The master's done flags are sticky and are cleared by its start edge one cycle after ISSUE. Because ISSUE always precedes WAIT, a stale done from the previous transaction is never sampled.
- Start is low in WAIT/RESP/IDLE, so consecutive transactions always produce a fresh rising edge at the master.
- Minimum latency: req_ready to rsp_valid = 3 cycles plus master/slave latency. Back-to-back grant spacing is at most 1 grant per 4 cycles.
- Simultaneous requests are resolved only by rr_ptr; read and write have no priority over each other.
- A requester that drops req_valid before req_ready is simply not granted.
- A requester re-asserting req_valid in the rsp_valid cycle is eligible at the next IDLE.
- System constraint: the slave holds rdata stable after the R handshake until the next read (the team's slaves register rdata).

Decomposition:
- axi_lite_pkg (existing) supplies addr_t, data_t, resp_t, RESP_OKAY.
- Add arb_state_t (IDLE, ISSUE, WAIT, RESP) to axi_lite_pkg.
- One sub-module, rr_arbiter: inputs req[NUM_REQ] and ptr; outputs grant_onehot, grant_idx and any_grant; purely combinational. Verify it standalone.

Test Plan:
- Single write: req 0 write addr 0x10, data 0xDEADBEEF, slave OKAY -> req_ready[0] once, mst_start_write high exactly 1 cycle, rsp_valid[0] once, rsp_error = 0, rsp_rdata = 0.
- Single read: req 2 read addr 0x20, slave returns 0x12345678 OKAY -> rsp_valid[2], rsp_rdata = 0x12345678, rsp_error = 0.
- Fairness: all 4 requesters held valid continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; no requester granted twice before all others.
- Error path: slave returns SLVERR for a write to 0x30 -> rsp_error = 1. Following read OKAY -> rsp_error = 0 (no stale error).
- Back-to-back: req 1 write then immediately read of the same address -> two distinct start rising edges, read returns the written value, no early done accepted.
- Reset in WAIT: rst low for 1 cycle mid-read -> all outputs 0, busy = 0, no rsp_valid, rr_ptr = 0 (next grant goes to the lowest valid index).
